inst_fetch_ctrl: RTL

Instruction-fetch sequencer for the pipeline's IF stage. Owns the program counter and drives the address of the combinational inst_memory. Registers the returned word into an IF/ID output slot with a valid/ready handshake toward decode. Handles stall back-pressure, branch/jump redirects, halt, and misaligned-redirect faults.

---
 rtl/inst_fetch_ctrl_if.sv | 61 ++++++
 rtl/inst_fetch_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-stage bus bundle: the instruction-memory port, redirect/halt control from
// later stages, and the IF/ID slot handshake toward decode.
//   master : used by inst_fetch_ctrl (drives imem_addr, if_*, fault)
//   slave  : used by the environment (drives imem_rdata, redirect_*, halt, if_ready)
// Optional macro: FETCH_PERF_EN adds fetch_count / stall_count.
interface inst_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus4;
  logic              fault;
`ifdef FETCH_PERF_EN
  logic [31:0]       fetch_count;
  logic [31:0]       stall_count;
`endif

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_plus4,
`ifdef FETCH_PERF_EN
    output fetch_count,
    output stall_count,
`endif
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4,
`ifdef FETCH_PERF_EN
    input  fetch_count,
    input  stall_count,
`endif
    input  fault
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer for the IF stage. Owns the PC, presents it to a
// combinational instruction memory, and registers the returned word into the
// IF/ID slot with a valid/ready handshake toward decode. Handles stalls,
// branch/jump redirects, halt, and a sticky fault on misaligned redirects.
// Ports:
//   clk    : clock, all state updates on posedge
//   reset  : synchronous active-high reset
//   bus    : inst_fetch_ctrl_if.master (imem_addr/imem_rdata, redirect_valid/
//            redirect_pc, halt, if_valid/if_ready, if_instr, if_pc,
//            if_pc_plus4, fault)
// Optional macro: FETCH_PERF_EN adds fetch_count (loads) and stall_count
// (RUN cycles with a valid slot blocked by decode).
module inst_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  inst_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    StRun,
    StHalt,
    StFault
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [ADDR_W-1:0] if_pc_plus4_q;
  logic              fault_q;

  logic              load_ok;
  logic              redir_ok;
  logic              redir_bad;
  logic              load_fire;
  logic [ADDR_W-1:0] pc_plus4;

  always_comb begin
    load_ok   = !valid_q || bus.if_ready;
    redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
    redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    // Wraps modulo 2^ADDR_W by construction.
    pc_plus4  = pc_q + ADDR_W'(4);
    // A redirect (aligned or not) pre-empts the load in the same cycle.
    load_fire = (state_q == StRun) && !bus.redirect_valid && load_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        StRun, StHalt: begin
          if (redir_ok) begin
            // Squash the slot even if decode takes it this cycle.
            pc_q    <= bus.redirect_pc;
            valid_q <= 1'b0;
            // Redirect beats halt in RUN; HALT only leaves once halt drops.
            state_q <= ((state_q == StHalt) && bus.halt) ? StHalt : StRun;
          end else if (redir_bad) begin
            fault_q <= 1'b1;
            valid_q <= 1'b0;
            state_q <= StFault;
          end else if (state_q == StRun) begin
            if (load_fire) begin
              instr_q       <= bus.imem_rdata;
              if_pc_q       <= pc_q;
              if_pc_plus4_q <= pc_plus4;
              valid_q       <= 1'b1;
              pc_q          <= pc_plus4;
            end
            // A halt arriving with a load still takes that load.
            state_q <= bus.halt ? StHalt : StRun;
          end else begin
            // HALT: no new fetches, but a pending slot may still drain.
            if (bus.if_ready) begin
              valid_q <= 1'b0;
            end
            state_q <= bus.halt ? StHalt : StRun;
          end
        end
        StFault: begin
          valid_q <= 1'b0;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StFault;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = valid_q;
  assign bus.if_instr    = instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus4 = if_pc_plus4_q;
  assign bus.fault       = fault_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;
  logic        stall_cyc;

  assign stall_cyc = (state_q == StRun) && valid_q && !bus.if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (load_fire) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (stall_cyc) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
`endif

endmodule
